axi4_rd_burst_master: RTL and testbench
=======================================

AXI4_RD_BURST_MASTER -- requirements
Module: axi4_rd_burst_master

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DWIDTH, 64, data width in bits; power of two, minimum 8.
- AWIDTH, 32, address width.
- IDWIDTH, 1, AXI ID width.
- MAX_BURST, 16, maximum beats per AR burst; 1..256.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, read command valid.
- cmd_ready, out, 1, command accepted when valid and ready are both high.
- cmd_addr, in, AWIDTH, byte start address.
- cmd_beats, in, 16, number of DWIDTH beats to read.
- m_axi, interface, -, axi4_rd_intf.host modport, parameterised with DWIDTH/AWIDTH/IDWIDTH.
- out_data, out, DWIDTH, read data.
- out_valid, out, 1, read data valid.
- out_ready, in, 1, downstream ready.
- out_last, out, 1, last beat of the command.
- err, out, 1, sticky: some beat of the current command had a nonzero rresp.
- err_cnt, out, 16, saturating count of error beats.

Function
REQ-003 The state machine SHALL have three states: IDLE, ADDR, DATA.
REQ-004 cmd_ready SHALL be high only in IDLE.
REQ-005 On accept with cmd_beats>0, the block SHALL latch the address with its low log2(DWIDTH/8) bits forced to 0, latch remaining=cmd_beats, clear err, and go to ADDR.
REQ-006 On accept with cmd_beats==0, the block SHALL stay in IDLE with no AXI traffic and no output beat.
REQ-007 In ADDR, burst length L SHALL equal min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
REQ-008 In ADDR, the block SHALL drive arlen=L-1 and arvalid=1, holding all AR fields stable until arready.
REQ-009 The AR handshake SHALL move the FSM to DATA.
REQ-010 Fixed AR fields SHALL be: arid=0, arsize=log2(DWIDTH/8), arburst=INCR (2'b01), arlock=0, arcache=4'b0011, arprot=0, arregion=0, arqos=0.
REQ-011 At most one burst SHALL be outstanding; arvalid SHALL be low outside ADDR.
REQ-012 In DATA, the R channel SHALL pass through combinationally: out_data=rdata, out_valid=rvalid, rready=out_ready.
- Zero added latency.
- rready SHALL be low outside DATA.
REQ-013 Each R handshake SHALL decrement remaining.
REQ-014 out_last SHALL be 1 only on the beat that takes remaining from 1 to 0.
REQ-015 On an R handshake with rlast=1, the FSM SHALL go to IDLE if remaining becomes 0, otherwise to ADDR.
- On the ADDR path, the address SHALL advance by L*DWIDTH/8.
REQ-016 An R handshake with rresp!=0 SHALL set err.
- err SHALL stay set until the next command accept; data SHALL still be forwarded.
REQ-017 An rlast that disagrees with the beat count SHALL be treated as an error (err set); the FSM SHALL follow the count, not rlast.
REQ-018 Address arithmetic SHALL wrap modulo 2^AWIDTH.
- A burst SHALL never cross a 4 KB boundary, including when the start address is exactly on a boundary (full MAX_BURST allowed).
REQ-019 Address advance and beat decrement on the same cycle SHALL both take effect.

Reset
REQ-020 While rst_n is low, the block SHALL be in IDLE with:
- arvalid=0, rready=0, out_valid=0, out_last=0;
- cmd_ready=0 during reset, 1 from the first clk edge after release;
- err=0, err_cnt=0, remaining=0, address=0.
REQ-021 Reset asserted mid-burst SHALL abort immediately with no further AR issued; the slave side SHALL be reset by the same rst_n.

Configuration
REQ-022 With macro AXI4_RD_BURST_MASTER_ERR_CNT_EN defined:
- err_cnt SHALL increment on every R handshake with rresp!=0;
- err_cnt SHALL saturate at 16'hFFFF and clear only on reset.
REQ-023 With the macro undefined, err_cnt SHALL be tied to 0 and no counter logic SHALL exist; err behaviour SHALL be unchanged.

Verification
REQ-024 cmd_addr=0x1000, beats=40, MAX_BURST=16 -> bursts (addr, arlen): (0x1000,15), (0x1080,15), (0x1100,7); out_last only on beat 40.
REQ-025 cmd_addr=0x0FE0, beats=10, DWIDTH=64 -> bursts (0x0FE0,3) then (0x1000,5); no burst crosses 4 KB.
REQ-026 out_ready toggled 1-0-1 per cycle and arready delayed 5 cycles -> all 40 beats delivered in order, no loss or duplication; AR fields stable while arvalid is high.
REQ-027 rresp=2'b10 on beat 3 of 8 -> err=1 through the end of the command, cleared on the next accept; err_cnt=1 with the macro, 0 without.
REQ-028 cmd_beats=0 -> no arvalid and no out_valid, cmd_ready stays high; rst_n pulsed low during DATA -> all outputs at reset values in the same cycle, IDLE after release.

Source files
------------

// File: rtl/axi4_rd_burst_master_if.sv
// AXI4 read-address / read-data channel bundle for axi4_rd_burst_master.
// host and master are the same view; slave is the memory side.
interface axi4_rd_intf #(
  parameter int DWIDTH  = 64,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 1
) ();
  logic [IDWIDTH-1:0] arid;
  logic [AWIDTH-1:0]  araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic               arlock;
  logic [3:0]         arcache;
  logic [2:0]         arprot;
  logic [3:0]         arregion;
  logic [3:0]         arqos;
  logic               arvalid;
  logic               arready;
  logic [IDWIDTH-1:0] rid;
  logic [DWIDTH-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport host (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arregion, arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arregion, arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arregion, arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_rd_burst_master.sv
// AXI4 read burst master: splits a beat-count command into 4 KB-safe INCR bursts.
// Optional saturating error-beat counter enabled by AXI4_RD_BURST_MASTER_ERR_CNT_EN.
module axi4_rd_burst_master #(
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 32,
  parameter int IDWIDTH   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [15:0]       cmd_beats,
  axi4_rd_intf.host         m_axi,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              err,
  output logic [15:0]       err_cnt
);

  localparam int BYTES = DWIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [AWIDTH-1:0] ALIGN_MASK = {AWIDTH{1'b1}} << SIZE;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nx;
  logic [AWIDTH-1:0] addr;
  logic [15:0]       remaining;
  logic [8:0]        burst_len;
  logic [8:0]        burst_left;
  logic              alive;

  logic [12:0]       page_beats;
  logic [8:0]        rem_cap;
  logic [8:0]        len;
  logic              accept;
  logic              r_hs;
  logic              burst_end;

  // Burst length: min(remaining, MAX_BURST, beats left in the current 4 KB page)
  always_comb begin
    page_beats = (13'h1000 - {1'b0, addr[11:0]}) >> SIZE;
    rem_cap    = (remaining > 16'(MAX_BURST)) ? 9'(MAX_BURST) : remaining[8:0];
    len        = ({4'b0, rem_cap} > page_beats) ? page_beats[8:0] : rem_cap;
  end

  assign accept    = cmd_valid && cmd_ready;
  assign r_hs      = (state == DATA) && m_axi.rvalid && out_ready;
  assign burst_end = (burst_left == 9'd1);

  always_comb begin
    state_nx  = state;
    cmd_ready = alive && (state == IDLE);
    case (state)
      IDLE: if (cmd_valid && alive && cmd_beats != 16'd0) state_nx = ADDR;
      ADDR: if (m_axi.arready) state_nx = DATA;
      DATA: if (r_hs && burst_end) state_nx = (remaining == 16'd1) ? IDLE : ADDR;
      default: state_nx = IDLE;
    endcase
  end

  // The beat count, not rlast, decides where each burst ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alive      <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      burst_len  <= '0;
      burst_left <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
      if (accept) begin
        err <= 1'b0;
        if (cmd_beats != 16'd0) begin
          addr      <= cmd_addr & ALIGN_MASK;
          remaining <= cmd_beats;
        end
      end
      if (state == ADDR && m_axi.arready) begin
        burst_len  <= len;
        burst_left <= len;
      end
      if (r_hs) begin
        remaining  <= remaining - 16'd1;
        burst_left <= burst_left - 9'd1;
        if (m_axi.rresp != 2'b00 || m_axi.rlast != burst_end) err <= 1'b1;
        if (burst_end && remaining != 16'd1)
          addr <= addr + (AWIDTH'(burst_len) << SIZE);
      end
    end
  end

`ifdef AXI4_RD_BURST_MASTER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (r_hs && m_axi.rresp != 2'b00 && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

  assign m_axi.arid     = '0;
  assign m_axi.araddr   = addr;
  assign m_axi.arlen    = 8'(len - 9'd1);
  assign m_axi.arsize   = 3'(SIZE);
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'b0011;
  assign m_axi.arprot   = '0;
  assign m_axi.arregion = '0;
  assign m_axi.arqos    = '0;
  assign m_axi.arvalid  = (state == ADDR);
  assign m_axi.rready   = (state == DATA) && out_ready;

  assign out_data  = m_axi.rdata;
  assign out_valid = (state == DATA) && m_axi.rvalid;
  assign out_last  = out_valid && (remaining == 16'd1);

endmodule

// File: tb/tb_axi4_rd_burst_master.sv
// Directed bench for axi4_rd_burst_master with a burst-plan model and an AXI slave.
module tb_axi4_rd_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        err;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  axi4_rd_intf #(.DWIDTH(64), .AWIDTH(32), .IDWIDTH(1)) axi ();

  axi4_rd_burst_master #(.DWIDTH(64), .AWIDTH(32), .IDWIDTH(1), .MAX_BURST(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .m_axi     (axi),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // ---- burst-plan model ----
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [31:0] base;
  int          bi, k, total, lastcnt, eb_cur;
  int          exp_errcnt = 0;
  bit          ar_pend = 1'b0;
  logic [31:0] ar_addr_prev;
  logic [7:0]  ar_len_prev;

  task automatic build_model(input logic [31:0] a, input int beats);
    int rem, pg, l;
    logic [31:0] cur;
    exp_addr.delete();
    exp_len.delete();
    base = a & 32'hFFFF_FFF8;
    cur  = base;
    rem  = beats;
    while (rem > 0) begin
      pg = (4096 - int'(cur % 4096)) / 8;
      l  = rem;
      if (l > 16) l = 16;
      if (l > pg) l = pg;
      exp_addr.push_back(cur);
      exp_len.push_back(l);
      cur = cur + 32'(l * 8);
      rem = rem - l;
    end
    bi = 0; k = 0; total = beats; lastcnt = 0;
  endtask

  // ---- slave stimulus knobs and state ----
  int          ar_delay = 0;
  int          err_beat = 0;
  bit          bad_rlast = 1'b0;
  bit          toggle = 1'b0;
  int          cmd_beat = 0;
  logic [31:0] qa[$];
  int          ql[$];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = toggle ? !out_ready : 1'b1;
    end
  end

  initial begin
    bit s_ar, s_r, s_arv;
    logic [31:0] s_addr;
    int s_len, ar_wait, rbeat;
    ar_wait = 0; rbeat = 0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rid = '0;
    forever begin
      @(negedge clk);
      s_ar   = axi.arvalid && axi.arready;
      s_arv  = axi.arvalid;
      s_addr = axi.araddr;
      s_len  = int'(axi.arlen);
      s_r    = axi.rvalid && axi.rready;
      @(posedge clk); #1;
      if (!rst_n) begin
        qa.delete(); ql.delete();
        ar_wait = 0; rbeat = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      end else begin
        if (s_ar) begin
          qa.push_back(s_addr); ql.push_back(s_len); ar_wait = 0;
        end else if (s_arv) ar_wait++;
        if (s_r && ql.size() > 0) begin
          cmd_beat++; rbeat++;
          if (rbeat > ql[0]) begin
            void'(qa.pop_front()); void'(ql.pop_front()); rbeat = 0;
          end
        end
        axi.arready = axi.arvalid && (ar_wait >= ar_delay);
        if (qa.size() > 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = pat(qa[0] + 32'(rbeat * 8));
          axi.rlast  = (rbeat == ql[0]) && !bad_rlast;
          axi.rresp  = (cmd_beat + 1 == err_beat) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        end
      end
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.arvalid) begin
        chk("ar_fixed",
            64'({axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache,
                 axi.arprot, axi.arregion, axi.arqos}),
            64'({1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000}));
        chk("ar_in_plan", 64'(bi < exp_addr.size()), 64'd1);
        if (bi < exp_addr.size()) begin
          chk("araddr", 64'(axi.araddr), 64'(exp_addr[bi]));
          chk("arlen", 64'(axi.arlen), 64'(exp_len[bi] - 1));
        end
        if (ar_pend) chk("ar_stable", 64'({axi.araddr, axi.arlen}), 64'({ar_addr_prev, ar_len_prev}));
        ar_pend      = !axi.arready;
        ar_addr_prev = axi.araddr;
        ar_len_prev  = axi.arlen;
        if (axi.arready) bi++;
      end else begin
        chk("ar_not_dropped", 64'(ar_pend), 64'd0);
        ar_pend = 1'b0;
      end
      chk("one_outstanding", 64'(axi.arvalid && axi.rready), 64'd0);
      chk("out_valid", 64'(out_valid), 64'(axi.rvalid));
      if (out_valid) begin
        if (eb_cur > 0 && k >= eb_cur) chk("err_held", 64'(err), 64'd1);
        chk("rready", 64'(axi.rready), 64'(out_ready));
        chk("beat_in_plan", 64'(k < total), 64'd1);
        chk("out_data", out_data, pat(base + 32'(k * 8)));
        chk("out_last", 64'(out_last), 64'(k == total - 1));
        if (out_ready) begin
          k++;
          if (out_last) lastcnt++;
        end
      end else begin
        chk("last_idle", 64'(out_last), 64'd0);
      end
    end
  end

  task automatic issue_cmd(input logic [31:0] a, input int beats);
    int c;
    for (c = 0; c < 200 && !cmd_ready; c++) @(negedge clk);
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = 16'(beats);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("err_clear_on_accept", 64'(err), 64'd0);
  endtask

  task automatic run_cmd(input logic [31:0] a, input int beats, input int dly,
                         input bit tog, input int eb, input bit badl);
    bit done;
    ar_delay = dly; toggle = tog; err_beat = eb; bad_rlast = badl; eb_cur = eb;
    cmd_beat = 0;
    build_model(a, beats);
    issue_cmd(a, beats);
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (k == total && bi == exp_addr.size() && cmd_ready) done = 1'b1;
    end
    chk("cmd_complete", 64'(done), 64'd1);
    chk("bursts_done", 64'(bi), 64'(exp_addr.size()));
    chk("beats_done", 64'(k), 64'(beats));
    chk("last_count", 64'(lastcnt), 64'(beats > 0));
    chk("err_final", 64'(err), 64'(eb > 0 || badl));
`ifdef AXI4_RD_BURST_MASTER_ERR_CNT_EN
    if (eb > 0 && exp_errcnt < 65535) exp_errcnt++;
`endif
    chk("err_cnt", 64'(err_cnt), 64'(exp_errcnt));
    toggle = 1'b0; err_beat = 0; bad_rlast = 1'b0; eb_cur = 0;
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
    eb_cur = 0; total = 0; k = 0; bi = 0; lastcnt = 0; base = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

    // Pin the plan model against hand-computed bursts
    build_model(32'h1000, 40);
    chk("plan40_n", 64'(exp_addr.size()), 64'd3);
    chk("plan40_b0", 64'({exp_addr[0], 32'(exp_len[0])}), {32'h1000, 32'd16});
    chk("plan40_b1", 64'({exp_addr[1], 32'(exp_len[1])}), {32'h1080, 32'd16});
    chk("plan40_b2", 64'({exp_addr[2], 32'(exp_len[2])}), {32'h1100, 32'd8});
    build_model(32'h0FE0, 10);
    chk("plan4k_n", 64'(exp_addr.size()), 64'd2);
    chk("plan4k_b0", 64'({exp_addr[0], 32'(exp_len[0])}), {32'h0FE0, 32'd4});
    chk("plan4k_b1", 64'({exp_addr[1], 32'(exp_len[1])}), {32'h1000, 32'd6});
    build_model(32'hFFFF_FFF0, 4);
    chk("planwrap_b0", 64'({exp_addr[0], 32'(exp_len[0])}), {32'hFFFF_FFF0, 32'd2});
    chk("planwrap_b1", 64'({exp_addr[1], 32'(exp_len[1])}), {32'h0000_0000, 32'd2});

    run_cmd(32'h1000, 40, 0, 1'b0, 0, 1'b0);
    run_cmd(32'h0FE0, 10, 0, 1'b0, 0, 1'b0);
    run_cmd(32'h2000, 40, 5, 1'b1, 0, 1'b0);
    run_cmd(32'h3000, 8, 0, 1'b0, 3, 1'b0);
    run_cmd(32'h4000, 4, 0, 1'b0, 0, 1'b0);
    run_cmd(32'h5007, 3, 1, 1'b0, 0, 1'b0);
    run_cmd(32'hFFFF_FFF0, 4, 0, 1'b0, 0, 1'b0);
    run_cmd(32'h6000, 20, 2, 1'b0, 0, 1'b1);

    // Zero-beat command: accepted but nothing happens
    build_model(32'h5000, 0);
    issue_cmd(32'h5000, 0);
    repeat (10) begin
      @(negedge clk);
      chk("zero_arvalid", 64'(axi.arvalid), 64'd0);
      chk("zero_out_valid", 64'(out_valid), 64'd0);
      chk("zero_cmd_ready", 64'(cmd_ready), 64'd1);
    end

    // Reset in the middle of the data phase
    build_model(32'h7000, 40);
    cmd_beat = 0;
    issue_cmd(32'h7000, 40);
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      @(negedge clk);
      if (k >= 5 && out_valid) reached = 1'b1;
    end
    chk("reached_data", 64'(reached), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_arvalid", 64'(axi.arvalid), 64'd0);
    chk("abort_rready", 64'(axi.rready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_last", 64'(out_last), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_err_cnt", 64'(err_cnt), 64'd0);
    exp_errcnt = 0;
    exp_addr.delete(); exp_len.delete();
    total = 0; k = 0; bi = 0; ar_pend = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_idle", 64'(cmd_ready), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("post_abort_no_ar", 64'(axi.arvalid), 64'd0);
    end
    run_cmd(32'h8000, 5, 0, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
